// File: rtl/csa_accum_pkg.sv
// ----------------------------------------------------------------------------
// csa_accum_pkg
// Shared types and helpers for the streaming carry-save accumulator.
//   csa_state_t : accumulator control states
//   out_width() : result width that can hold MAX_OPS operands without overflow
// ----------------------------------------------------------------------------
package csa_accum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    HOLD    = 2'd3
  } csa_state_t;

  // Sum of up to max_ops values of width bits needs width + clog2(max_ops) bits.
  function automatic int out_width(input int width, input int max_ops);
    return width + $clog2(max_ops);
  endfunction

endpackage

// File: rtl/csa_accum_if.sv
// ----------------------------------------------------------------------------
// csa_accum_if
// Operand stream and result stream of csa_accum.
//   in_valid/in_ready/in_data/in_last        : operand stream (master -> slave)
//   out_valid/out_ready/out_sum/out_count/
//   out_trunc                                : result stream (slave -> master)
// Macro CSA_SIGNED_EN: out_sum is declared signed (two's complement operands).
// ----------------------------------------------------------------------------
interface csa_accum_if #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8
);
  import csa_accum_pkg::*;

  localparam int OUT_W = out_width(WIDTH, MAX_OPS);
  localparam int CNT_W = $clog2(MAX_OPS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
`ifdef CSA_SIGNED_EN
  logic signed [OUT_W-1:0] out_sum;
`else
  logic [OUT_W-1:0] out_sum;
`endif
  logic [CNT_W-1:0] out_count;
  logic             out_trunc;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_trunc
  );

endinterface

// File: rtl/csa_accum_rca_n.sv
// ----------------------------------------------------------------------------
// rca_n
// N-bit ripple-carry adder built from full-adder cells.
//   a, b  : addends          c_in  : carry into bit 0
//   sum   : N-bit sum        c_out : carry out of bit N-1
// ----------------------------------------------------------------------------
module rca_n #(
  parameter int N = 7
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] carry_s;

  assign carry_s[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
  end

  assign c_out = carry_s[N];

endmodule

// File: rtl/csa_accum.sv
// ----------------------------------------------------------------------------
// csa_accum
// Streaming multi-operand accumulator. Operands are folded into a carry-save
// pair (s, c) with one 3:2 compression per accepted beat; the pair is resolved
// by a ripple-carry pass once the burst ends (in_last, or MAX_OPS operands).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csa_accum_if.slave (operand stream in, result stream out)
// Macro CSA_SIGNED_EN: operands are sign-extended (two's complement result);
// otherwise operands are zero-extended.
// ----------------------------------------------------------------------------
module csa_accum
  import csa_accum_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  csa_accum_if.slave bus
);

  localparam int OUT_W = out_width(WIDTH, MAX_OPS);
  localparam int CNT_W = $clog2(MAX_OPS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  csa_state_t       state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             trunc_q, trunc_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_trunc_q, out_trunc_d;

  logic [OUT_W-1:0] a_ext_s;
  logic [OUT_W-1:0] csa_s_s;
  logic [OUT_W-1:0] csa_c_s;
  logic [CNT_W-1:0] count_inc_s;
  logic [OUT_W-1:0] rca_sum_s;
  logic             rca_cout_unused_s;
  logic             in_ready_s;
  logic             accept_s;

`ifdef CSA_SIGNED_EN
  assign a_ext_s = {{(OUT_W-WIDTH){bus.in_data[WIDTH-1]}}, bus.in_data};
`else
  assign a_ext_s = {{(OUT_W-WIDTH){1'b0}}, bus.in_data};
`endif

  // 3:2 compression; the carry vector drops its top bit, which is harmless
  // because the true sum always fits in OUT_W bits (modulo 2^OUT_W when signed).
  assign csa_s_s = s_q ^ c_q ^ a_ext_s;
  assign csa_c_s = ((s_q & c_q) | (s_q & a_ext_s) | (c_q & a_ext_s)) << 1;

  assign count_inc_s = count_q + CNT_W'(1);

  assign in_ready_s = (state_q == IDLE) || (state_q == ACC);
  assign accept_s   = bus.in_valid & in_ready_s;

  rca_n #(.N(OUT_W)) u_rca (
    .a     (s_q),
    .b     (c_q),
    .c_in  (1'b0),
    .sum   (rca_sum_s),
    .c_out (rca_cout_unused_s)
  );

  // Next-state, accumulator and result-register update.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          s_d     = a_ext_s;
          c_d     = {OUT_W{1'b0}};
          count_d = CNT_W'(1);
          trunc_d = 1'b0;
          state_d = bus.in_last ? RESOLVE : ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          s_d     = csa_s_s;
          c_d     = csa_c_s;
          count_d = count_inc_s;
          trunc_d = (count_inc_s == MAX_CNT) & ~bus.in_last;
          if (bus.in_last || (count_inc_s == MAX_CNT)) begin
            state_d = RESOLVE;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      RESOLVE: begin
        out_sum_d   = rca_sum_s;
        out_count_d = count_q;
        out_trunc_d = trunc_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          s_d         = {OUT_W{1'b0}};
          c_d         = {OUT_W{1'b0}};
          count_d     = {CNT_W{1'b0}};
          trunc_d     = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= {OUT_W{1'b0}};
      c_q         <= {OUT_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      trunc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= {OUT_W{1'b0}};
      out_count_q <= {CNT_W{1'b0}};
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_csa_accum.sv
// ----------------------------------------------------------------------------
// tb_csa_accum
// Bench for csa_accum (WIDTH=4, MAX_OPS=8). Expected results come from a
// burst-level model: the operands of a burst are kept in a queue and summed
// with plain integer arithmetic when the burst ends.
// Macro CSA_SIGNED_EN: the model treats operands as two's complement.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csa_accum;

  localparam int WIDTH   = 4;
  localparam int MAX_OPS = 8;
  localparam int OUT_W   = WIDTH + $clog2(MAX_OPS);
  localparam int CNT_W   = $clog2(MAX_OPS + 1);

  typedef struct {
    int sum;
    int cnt;
    int trunc;
  } exp_t;

  logic clk;
  logic rst_n;

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  int   ops[$];
  bit   rand_ready;
  bit   prev_hold;
  int   prev_sum;

  csa_accum_if #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) bus ();

  csa_accum #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ext(input int v);
`ifdef CSA_SIGNED_EN
    return (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
`else
    return v;
`endif
  endfunction

  // Record one accepted operand; close the burst when it ends.
  task automatic model_beat(input int d, input bit last);
    int   tot;
    exp_t e;
    ops.push_back(d);
    if (last || ops.size() == MAX_OPS) begin
      tot = 0;
      foreach (ops[i]) tot += ext(ops[i]);
      e.sum   = tot & ((1 << OUT_W) - 1);
      e.cnt   = ops.size();
      e.trunc = (ops.size() == MAX_OPS && !last) ? 1 : 0;
      exp_q.push_back(e);
      ops.delete();
    end
  endtask

  // Present one operand and wait (bounded) until it is accepted.
  task automatic send_beat(input int d, input bit last);
    bit accepted;
    accepted     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(d);
    bus.in_last  = last;
    for (int k = 0; k < 64; k++) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
      if (accepted) break;
    end
    check_eq("accept_timeout", accepted, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (accepted) model_beat(d, last);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  // Result scoreboard: compare on each handshake, and check stability in HOLD.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_sum", bus.out_sum, prev_sum);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_sum", bus.out_sum, e.sum);
          check_eq("out_count", bus.out_count, e.cnt);
          check_eq("out_trunc", bus.out_trunc, e.trunc);
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_sum  = int'(bus.out_sum);
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rand_ready    = 1'b0;
    prev_hold     = 1'b0;
    prev_sum      = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_sum", bus.out_sum, 0);
    check_eq("rst_out_count", bus.out_count, 0);
    check_eq("rst_out_trunc", bus.out_trunc, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Burst 3,5,7 with latency and one-cycle pulse check.
    send_beat(3, 0);
    send_beat(5, 0);
    send_beat(7, 1);
    check_eq("lat_t1_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    check_eq("lat_t2_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    check_eq("pulse_one_cycle", bus.out_valid, 0);
    check_eq("retain_sum", bus.out_sum, ext(3) + ext(5) + ext(7) & 127);
    wait_drain();

    // Eight operands without last, then a ninth beat forming its own burst.
    for (int i = 0; i < MAX_OPS; i++) send_beat(15, 0);
    send_beat(2, 1);
    wait_drain();

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    send_beat(1, 0);
    send_beat(2, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", bus.out_valid, 1);
      check_eq("bp_sum", bus.out_sum, 3);
      check_eq("bp_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_after_valid", bus.out_valid, 0);
    check_eq("bp_after_idle", bus.in_ready, 1);
    check_eq("bp_after_sum", bus.out_sum, 3);
    wait_drain();

    // Bubbles between operands, then a single-operand burst.
    send_beat(4, 0);
    repeat (3) @(posedge clk);
    #1;
    send_beat(6, 1);
    send_beat(9, 1);
    wait_drain();

    // Reset mid-burst discards partial state.
    send_beat(1, 0);
    send_beat(2, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", bus.out_valid, 0);
    check_eq("midrst_in_ready", bus.in_ready, 1);
    ops.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while a result is held drops out_valid without a clock edge.
    bus.out_ready = 1'b0;
    send_beat(5, 0);
    send_beat(6, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("hold_before_rst", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", bus.out_valid, 0);
    check_eq("async_rst_sum", bus.out_sum, 0);
    exp_q.delete();
    ops.delete();
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    send_beat(1, 1);
    wait_drain();

`ifdef CSA_SIGNED_EN
    send_beat(15, 0);
    send_beat(2, 1);
    for (int i = 0; i < MAX_OPS; i++) send_beat(8, 0);
    wait_drain();
`endif

    // Randomized bursts with random bubbles and random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_beat(int'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
    end
    send_beat(int'($urandom_range(0, 15)), 1'b1);
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
